// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: register-file addressing, MEM/WB forwarding,
// load-use and EX hazard stalls, and a registered ID/EX bundle with valid/ready.
module operand_fetch_stage #(
  parameter int unsigned DW  = 32,
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_instr,
  input  logic [DW-1:0]  in_pc,
  output logic [4:0]     rs,
  output logic [4:0]     rt,
  input  logic [DW-1:0]  ReadData1,
  input  logic [DW-1:0]  ReadData2,
  input  logic           ex_regwrite,
  input  logic [4:0]     ex_rd,
  input  logic           mem_regwrite,
  input  logic           mem_memread,
  input  logic [4:0]     mem_rd,
  input  logic [DW-1:0]  mem_result,
  input  logic           wb_regwrite,
  input  logic [4:0]     wb_rd,
  input  logic [DW-1:0]  wb_result,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_pc,
  output logic [DW-1:0]  out_opA,
  output logic [DW-1:0]  out_opB,
  output logic [DW-1:0]  out_imm,
  output logic [4:0]     out_dest,
  output logic [5:0]     out_opcode,
  output logic [5:0]     out_funct,
  output logic [4:0]     out_shamt,
  output logic [SCW-1:0] stall_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HAZARD = 1'b1;

  logic [0:0]     r_state;
  logic           r_valid;
  logic [DW-1:0]  r_pc, r_opa, r_opb, r_imm;
  logic [4:0]     r_dest, r_shamt;
  logic [5:0]     r_opcode, r_funct;
  logic [SCW-1:0] r_stall_count;

  logic [0:0]     w_state_nxt;
  logic           w_valid_nxt;
  logic [DW-1:0]  w_pc_nxt, w_opa_nxt, w_opb_nxt, w_imm_nxt;
  logic [4:0]     w_dest_nxt, w_shamt_nxt;
  logic [5:0]     w_opcode_nxt, w_funct_nxt;
  logic [SCW-1:0] w_stall_count_nxt;

  logic [5:0]     w_opcode;
  logic           w_uses_rs, w_uses_rt;
  logic [4:0]     w_dest;
  logic [DW-1:0]  w_imm, w_opa, w_opb;
  logic           w_hazard, w_adv, w_accept;

  assign w_opcode = in_instr[31:26];
  assign rs       = in_instr[25:21];
  assign rt       = in_instr[20:16];

  // Operand usage, destination and immediate extension from the opcode.
  always_comb begin
    w_uses_rs = 1'b1;
    w_uses_rt = 1'b0;
    w_dest    = rt;
    w_imm     = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
    case (w_opcode)
      6'h02, 6'h03, 6'h0F: w_uses_rs = 1'b0;
      default:             w_uses_rs = 1'b1;
    endcase
    case (w_opcode)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h2B: w_uses_rt = 1'b1;
      default:                           w_uses_rt = 1'b0;
    endcase
    case (w_opcode)
      6'h00:                             w_dest = in_instr[15:11];
      6'h03:                             w_dest = 5'd31;
      6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h28, 6'h29, 6'h2B:               w_dest = 5'd0;
      default:                           w_dest = rt;
    endcase
    case (w_opcode)
      6'h0C, 6'h0D, 6'h0E: w_imm = {{(DW-16){1'b0}}, in_instr[15:0]};
      default:             w_imm = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
    endcase
  end

  function automatic logic [DW-1:0] f_fwd(
    input logic [4:0]    src,
    input logic [DW-1:0] rdata,
    input logic          m_we,
    input logic          m_rd_load,
    input logic [4:0]    m_rd,
    input logic [DW-1:0] m_res,
    input logic          w_we,
    input logic [4:0]    w_rd,
    input logic [DW-1:0] w_res
  );
    if (src == 5'd0)                          return '0;
    else if (m_we && !m_rd_load && m_rd == src) return m_res;
    else if (w_we && w_rd == src)             return w_res;
    else                                      return rdata;
  endfunction

  function automatic logic f_hit(
    input logic [4:0] src,
    input logic       used,
    input logic       e_we,
    input logic [4:0] e_rd,
    input logic       m_we,
    input logic       m_rd_load,
    input logic [4:0] m_rd
  );
    return used && (src != 5'd0) &&
           ((e_we && e_rd == src) || (m_we && m_rd_load && m_rd == src));
  endfunction

  assign w_opa = f_fwd(rs, ReadData1, mem_regwrite, mem_memread, mem_rd, mem_result,
                       wb_regwrite, wb_rd, wb_result);
  assign w_opb = f_fwd(rt, ReadData2, mem_regwrite, mem_memread, mem_rd, mem_result,
                       wb_regwrite, wb_rd, wb_result);

  assign w_hazard = in_valid &&
                    (f_hit(rs, w_uses_rs, ex_regwrite, ex_rd, mem_regwrite, mem_memread, mem_rd) ||
                     f_hit(rt, w_uses_rt, ex_regwrite, ex_rd, mem_regwrite, mem_memread, mem_rd));
  assign w_adv    = !r_valid || out_ready;
  assign in_ready = !reset && (flush || (w_adv && !w_hazard));
  assign w_accept = in_valid && in_ready;

  // Next-state: flush wins, then advance (load or bubble), otherwise hold.
  always_comb begin
    w_state_nxt       = r_state;
    w_valid_nxt       = r_valid;
    w_pc_nxt          = r_pc;
    w_opa_nxt         = r_opa;
    w_opb_nxt         = r_opb;
    w_imm_nxt         = r_imm;
    w_dest_nxt        = r_dest;
    w_opcode_nxt      = r_opcode;
    w_funct_nxt       = r_funct;
    w_shamt_nxt       = r_shamt;
    w_stall_count_nxt = r_stall_count;
    if (flush) begin
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_RUN;
    end else if (w_adv) begin
      if (w_accept) begin
        w_valid_nxt  = 1'b1;
        w_pc_nxt     = in_pc;
        w_opa_nxt    = w_opa;
        w_opb_nxt    = w_opb;
        w_imm_nxt    = w_imm;
        w_dest_nxt   = w_dest;
        w_opcode_nxt = w_opcode;
        w_funct_nxt  = in_instr[5:0];
        w_shamt_nxt  = in_instr[10:6];
      end else begin
        w_valid_nxt = 1'b0;
      end
      if (w_hazard) begin
        w_state_nxt = ST_HAZARD;
        if (r_stall_count != {SCW{1'b1}})
          w_stall_count_nxt = r_stall_count + SCW'(1);
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else if (!w_hazard) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_opa         <= '0;
      r_opb         <= '0;
      r_imm         <= '0;
      r_dest        <= '0;
      r_opcode      <= '0;
      r_funct       <= '0;
      r_shamt       <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_valid       <= w_valid_nxt;
      r_pc          <= w_pc_nxt;
      r_opa         <= w_opa_nxt;
      r_opb         <= w_opb_nxt;
      r_imm         <= w_imm_nxt;
      r_dest        <= w_dest_nxt;
      r_opcode      <= w_opcode_nxt;
      r_funct       <= w_funct_nxt;
      r_shamt       <= w_shamt_nxt;
      r_stall_count <= w_stall_count_nxt;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_opA     = r_opa;
  assign out_opB     = r_opb;
  assign out_imm     = r_imm;
  assign out_dest    = r_dest;
  assign out_opcode  = r_opcode;
  assign out_funct   = r_funct;
  assign out_shamt   = r_shamt;
  assign stall_count = r_stall_count;

endmodule
